// File: rtl/id_stage.sv
// rtl/id_stage.sv - instruction decode stage with load-use hazard stall and ID/EX pipeline register
//
// Purpose:
//   Drives reg_file read addresses from the fetched instruction.
//   Decodes control flags and captures operands, immediate and control into the ID/EX register.
//   Detects load-use hazards, stalls fetch for one cycle and inserts a bubble.
//   Counts stall cycles in a saturating counter.
//
// Optional feature macro: ID_WB_BYPASS_EN
//   When defined, a same-cycle writeback to a source register is forwarded into the captured operand.
//
// Ports:
//   Clk, Rst_n                       clock, asynchronous active-low reset
//   Instr, InstrValid, Flush         instruction from IF/ID, valid flag, squash request
//   Ard1, Ard2                       reg_file read addresses (rs, rt), combinational
//   Dout1, Dout2                     reg_file read data
//   WbAwr, WbDin, WbWrEn             writeback port (same nets as reg_file write port)
//   StallIF                          IF/ID hold request, combinational
//   ExValid .. ExIllegal             ID/EX pipeline register contents
//   StallCount                       saturating stall-cycle counter
module id_stage #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 5,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   Clk,
    input  logic                   Rst_n,
    input  logic [31:0]            Instr,
    input  logic                   InstrValid,
    input  logic                   Flush,
    output logic [ADDR_W-1:0]      Ard1,
    output logic [ADDR_W-1:0]      Ard2,
    input  logic [DATA_W-1:0]      Dout1,
    input  logic [DATA_W-1:0]      Dout2,
    input  logic [ADDR_W-1:0]      WbAwr,
    input  logic [DATA_W-1:0]      WbDin,
    input  logic                   WbWrEn,
    output logic                   StallIF,
    output logic                   ExValid,
    output logic [DATA_W-1:0]      ExRsData,
    output logic [DATA_W-1:0]      ExRtData,
    output logic [DATA_W-1:0]      ExImm,
    output logic [ADDR_W-1:0]      ExRd,
    output logic [5:0]             ExOpcode,
    output logic [5:0]             ExFunct,
    output logic                   ExRegWrite,
    output logic                   ExMemRead,
    output logic                   ExMemWrite,
    output logic                   ExBranch,
    output logic                   ExIllegal,
    output logic [STALL_CNT_W-1:0] StallCount
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic [ADDR_W-1:0] rd_field;
    logic [15:0]       imm16;

    assign opcode   = Instr[31:26];
    assign funct    = Instr[5:0];
    assign rs_addr  = ADDR_W'(Instr[25:21]);
    assign rt_addr  = ADDR_W'(Instr[20:16]);
    assign rd_field = ADDR_W'(Instr[15:11]);
    assign imm16    = Instr[15:0];

    assign Ard1 = rs_addr;
    assign Ard2 = rt_addr;

    logic [ADDR_W-1:0] dec_rd;
    logic              dec_rw;
    logic              dec_mr;
    logic              dec_mw;
    logic              dec_br;
    logic              dec_il;
    logic              uses_rt;
    logic              zero_ext;

    always_comb begin
        dec_rd   = '0;
        dec_rw   = 1'b0;
        dec_mr   = 1'b0;
        dec_mw   = 1'b0;
        dec_br   = 1'b0;
        dec_il   = 1'b0;
        uses_rt  = 1'b0;
        zero_ext = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                dec_rd  = rd_field;
                dec_rw  = 1'b1;
                uses_rt = 1'b1;
            end
            OP_ADDI: begin
                dec_rd = rt_addr;
                dec_rw = 1'b1;
            end
            OP_ANDI, OP_ORI: begin
                dec_rd   = rt_addr;
                dec_rw   = 1'b1;
                zero_ext = 1'b1;
            end
            OP_LW: begin
                dec_rd = rt_addr;
                dec_rw = 1'b1;
                dec_mr = 1'b1;
            end
            OP_SW: begin
                dec_mw  = 1'b1;
                uses_rt = 1'b1;
            end
            OP_BEQ: begin
                dec_br  = 1'b1;
                uses_rt = 1'b1;
            end
            default: dec_il = 1'b1;
        endcase
    end

    // Writes to $0 are architecturally discarded, so drop them here rather than in EX/WB.
    logic regwrite_eff;
    assign regwrite_eff = dec_rw && (dec_rd != '0);

    // The extension rule applies to every opcode so ExImm is always well defined.
    logic [DATA_W-1:0] imm_ext;
    assign imm_ext = zero_ext ? {{(DATA_W-16){1'b0}}, imm16}
                              : {{(DATA_W-16){imm16[15]}}, imm16};

    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;

`ifdef ID_WB_BYPASS_EN
    // reg_file does not show a same-cycle write on its read port, so forward it here.
    logic rs_fwd;
    logic rt_fwd;
    assign rs_fwd = WbWrEn && (WbAwr != '0) && (WbAwr == rs_addr);
    assign rt_fwd = WbWrEn && (WbAwr != '0) && (WbAwr == rt_addr);
    assign rs_val = (rs_addr == '0) ? '0 : (rs_fwd ? WbDin : Dout1);
    assign rt_val = (rt_addr == '0) ? '0 : (rt_fwd ? WbDin : Dout2);
`else
    logic unused_wb;
    assign unused_wb = ^{WbAwr, WbDin, WbWrEn};
    assign rs_val = (rs_addr == '0) ? '0 : Dout1;
    assign rt_val = (rt_addr == '0) ? '0 : Dout2;
`endif

    // The bubble inserted on a hazard clears ExMemRead, so the condition self-clears after one cycle.
    logic hazard;
    assign hazard = InstrValid && ExValid && ExMemRead && (ExRd != '0) &&
                    ((ExRd == rs_addr) || (uses_rt && (ExRd == rt_addr)));

    assign StallIF = hazard;

    logic load_bubble;
    assign load_bubble = Flush || hazard || !InstrValid;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            ExValid    <= 1'b0;
            ExRsData   <= '0;
            ExRtData   <= '0;
            ExImm      <= '0;
            ExRd       <= '0;
            ExOpcode   <= '0;
            ExFunct    <= '0;
            ExRegWrite <= 1'b0;
            ExMemRead  <= 1'b0;
            ExMemWrite <= 1'b0;
            ExBranch   <= 1'b0;
            ExIllegal  <= 1'b0;
        end else if (load_bubble) begin
            ExValid    <= 1'b0;
            ExRsData   <= '0;
            ExRtData   <= '0;
            ExImm      <= '0;
            ExRd       <= '0;
            ExOpcode   <= '0;
            ExFunct    <= '0;
            ExRegWrite <= 1'b0;
            ExMemRead  <= 1'b0;
            ExMemWrite <= 1'b0;
            ExBranch   <= 1'b0;
            ExIllegal  <= 1'b0;
        end else begin
            ExValid    <= 1'b1;
            ExRsData   <= rs_val;
            ExRtData   <= rt_val;
            ExImm      <= imm_ext;
            ExRd       <= dec_rd;
            ExOpcode   <= opcode;
            ExFunct    <= funct;
            ExRegWrite <= regwrite_eff;
            ExMemRead  <= dec_mr;
            ExMemWrite <= dec_mw;
            ExBranch   <= dec_br;
            ExIllegal  <= dec_il;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            StallCount <= '0;
        end else if (hazard && !(&StallCount)) begin
            StallCount <= StallCount + STALL_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - self-checking bench for id_stage with reference model and directed vectors
module tb_id_stage;

    localparam int CW = 4;
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic [31:0] Instr;
    logic        InstrValid;
    logic        Flush;
    logic [4:0]  Ard1, Ard2;
    logic [31:0] Dout1, Dout2;
    logic [4:0]  WbAwr;
    logic [31:0] WbDin;
    logic        WbWrEn;
    logic        StallIF;
    logic        ExValid;
    logic [31:0] ExRsData, ExRtData, ExImm;
    logic [4:0]  ExRd;
    logic [5:0]  ExOpcode, ExFunct;
    logic        ExRegWrite, ExMemRead, ExMemWrite, ExBranch, ExIllegal;
    logic [CW-1:0] StallCount;

    int checks = 0;
    int errors = 0;

    id_stage #(.DATA_W(32), .ADDR_W(5), .STALL_CNT_W(CW)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Instr(Instr), .InstrValid(InstrValid), .Flush(Flush),
        .Ard1(Ard1), .Ard2(Ard2), .Dout1(Dout1), .Dout2(Dout2),
        .WbAwr(WbAwr), .WbDin(WbDin), .WbWrEn(WbWrEn), .StallIF(StallIF),
        .ExValid(ExValid), .ExRsData(ExRsData), .ExRtData(ExRtData), .ExImm(ExImm),
        .ExRd(ExRd), .ExOpcode(ExOpcode), .ExFunct(ExFunct), .ExRegWrite(ExRegWrite),
        .ExMemRead(ExMemRead), .ExMemWrite(ExMemWrite), .ExBranch(ExBranch),
        .ExIllegal(ExIllegal), .StallCount(StallCount)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the ID/EX register contents as the spec's rules describe them.
    logic        m_valid = 0;
    logic [31:0] m_rs = 0, m_rt = 0, m_imm = 0;
    logic [4:0]  m_rd = 0;
    logic [5:0]  m_op = 0, m_fn = 0;
    logic        m_rw = 0, m_mr = 0, m_mw = 0, m_br = 0, m_il = 0;
    logic [CW-1:0] m_cnt = 0;

    function automatic logic reads_rt(input logic [5:0] op);
        return (op == 6'h00) || (op == 6'h2B) || (op == 6'h04);
    endfunction

    function automatic logic model_hazard();
        logic [4:0] rs, rt;
        rs = Instr[25:21];
        rt = Instr[20:16];
        if (!(InstrValid && m_valid && m_mr) || m_rd == 5'd0) return 1'b0;
        return (m_rd == rs) || (reads_rt(Instr[31:26]) && m_rd == rt);
    endfunction

    function automatic logic [31:0] operand(input logic [4:0] a, input logic [31:0] d);
        if (a == 5'd0) return 32'd0;
`ifdef ID_WB_BYPASS_EN
        if (WbWrEn && WbAwr == a) return WbDin;
`endif
        return d;
    endfunction

    always @(posedge Clk or negedge Rst_n) begin
        logic haz;
        logic [5:0] op;
        logic writes_rt;
        if (!Rst_n) begin
            {m_valid, m_rs, m_rt, m_imm, m_rd, m_op, m_fn} = '0;
            {m_rw, m_mr, m_mw, m_br, m_il} = '0;
            m_cnt = '0;
        end else begin
            haz = model_hazard();
            if (haz && m_cnt != CNT_MAX) m_cnt = m_cnt + 1'b1;
            if (Flush || haz || !InstrValid) begin
                {m_valid, m_rs, m_rt, m_imm, m_rd, m_op, m_fn} = '0;
                {m_rw, m_mr, m_mw, m_br, m_il} = '0;
            end else begin
                op        = Instr[31:26];
                writes_rt = (op == 6'h08) || (op == 6'h0C) || (op == 6'h0D) || (op == 6'h23);
                m_valid   = 1'b1;
                m_op      = op;
                m_fn      = Instr[5:0];
                m_rd      = (op == 6'h00) ? Instr[15:11] : (writes_rt ? Instr[20:16] : 5'd0);
                m_rw      = ((op == 6'h00) || writes_rt) && (m_rd != 5'd0);
                m_mr      = (op == 6'h23);
                m_mw      = (op == 6'h2B);
                m_br      = (op == 6'h04);
                m_il      = !((op == 6'h00) || writes_rt || m_mw || m_br);
                m_imm     = (op == 6'h0C || op == 6'h0D) ? {16'h0, Instr[15:0]}
                                                         : {{16{Instr[15]}}, Instr[15:0]};
                m_rs      = operand(Instr[25:21], Dout1);
                m_rt      = operand(Instr[20:16], Dout2);
            end
        end
    end

    always @(negedge Clk) begin
        chk("ExValid", 32'(ExValid), 32'(m_valid));
        chk("ExRsData", ExRsData, m_rs);
        chk("ExRtData", ExRtData, m_rt);
        chk("ExImm", ExImm, m_imm);
        chk("ExRd", 32'(ExRd), 32'(m_rd));
        chk("ExOpcode", 32'(ExOpcode), 32'(m_op));
        chk("ExFunct", 32'(ExFunct), 32'(m_fn));
        chk("ExRegWrite", 32'(ExRegWrite), 32'(m_rw));
        chk("ExMemRead", 32'(ExMemRead), 32'(m_mr));
        chk("ExMemWrite", 32'(ExMemWrite), 32'(m_mw));
        chk("ExBranch", 32'(ExBranch), 32'(m_br));
        chk("ExIllegal", 32'(ExIllegal), 32'(m_il));
        chk("StallCount", 32'(StallCount), 32'(m_cnt));
        chk("StallIF", 32'(StallIF), 32'(model_hazard()));
        chk("Ard1", 32'(Ard1), 32'(Instr[25:21]));
        chk("Ard2", 32'(Ard2), 32'(Instr[20:16]));
    end

    task automatic drive(input logic [31:0] i, input logic v, input logic f,
                         input logic [31:0] d1, input logic [31:0] d2,
                         input logic [4:0] wa, input logic [31:0] wd, input logic we);
        Instr = i; InstrValid = v; Flush = f; Dout1 = d1; Dout2 = d2;
        WbAwr = wa; WbDin = wd; WbWrEn = we;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    localparam logic [31:0] ADDI  = 32'h2143FFFC; // addi $3,$10,-4
    localparam logic [31:0] ORI   = 32'h34058001; // ori  $5,$0,0x8001
    localparam logic [31:0] LW    = 32'h8D430000; // lw   $3,0($10)
    localparam logic [31:0] ADD   = 32'h00622020; // add  $4,$3,$2
    localparam logic [31:0] ILL   = 32'hFC430000; // opcode 0x3F
    localparam logic [31:0] ADDI0 = 32'h20200005; // addi $0,$1,5
    localparam logic [31:0] ADDI3 = 32'h20230001; // addi $3,$1,1
    localparam logic [31:0] BEQ   = 32'h10430004; // beq  $2,$3,4

    initial begin
        Rst_n = 1'b0;
        drive(32'h0, 0, 0, 0, 0, 0, 0, 0);
        #3;
        chk("rst ExValid", 32'(ExValid), 0);
        chk("rst StallCount", 32'(StallCount), 0);
        chk("rst StallIF", 32'(StallIF), 0);
        @(negedge Clk);
        Rst_n = 1'b1;
        tick();

        drive(ADDI, 1, 0, 32, 7, 0, 0, 0);
        #1;
        chk("addi Ard1", 32'(Ard1), 10);
        chk("addi Ard2", 32'(Ard2), 3);
        tick();
        chk("addi ExValid", 32'(ExValid), 1);
        chk("addi ExRsData", ExRsData, 32);
        chk("addi ExImm", ExImm, 32'hFFFFFFFC);
        chk("addi ExRd", 32'(ExRd), 3);
        chk("addi ExRegWrite", 32'(ExRegWrite), 1);

        drive(ORI, 1, 0, 32'hDEADBEEF, 1, 0, 0, 0);
        tick();
        chk("ori ExImm", ExImm, 32'h00008001);
        chk("ori ExRsData", ExRsData, 0);
        chk("ori ExRd", 32'(ExRd), 5);

        drive(LW, 1, 0, 32'h100, 0, 0, 0, 0);
        tick();
        chk("lw ExMemRead", 32'(ExMemRead), 1);
        drive(ADD, 1, 0, 32'h11, 32'h22, 0, 0, 0);
        #1;
        chk("lu StallIF", 32'(StallIF), 1);
        tick();
        chk("lu bubble ExValid", 32'(ExValid), 0);
        chk("lu StallIF clear", 32'(StallIF), 0);
        tick();
        chk("lu add ExValid", 32'(ExValid), 1);
        chk("lu add ExRd", 32'(ExRd), 4);
        chk("lu add ExRsData", ExRsData, 32'h11);
        chk("lu StallCount", 32'(StallCount), 1);

        drive(LW, 1, 0, 0, 0, 0, 0, 0);
        tick();
        drive(ADD, 1, 1, 1, 2, 0, 0, 0);
        #1;
        chk("flush+haz StallIF", 32'(StallIF), 1);
        tick();
        chk("flush+haz ExValid", 32'(ExValid), 0);
        chk("flush+haz ExRegWrite", 32'(ExRegWrite), 0);
        chk("flush+haz StallCount", 32'(StallCount), 2);
        drive(ADDI, 1, 1, 5, 5, 0, 0, 0);
        tick();
        chk("flush ExValid", 32'(ExValid), 0);
        chk("flush ExRegWrite", 32'(ExRegWrite), 0);

        drive(ADD, 1, 0, 32, 9, 3, 2, 1);
        tick();
`ifdef ID_WB_BYPASS_EN
        chk("bypass ExRsData", ExRsData, 2);
`else
        chk("nobypass ExRsData", ExRsData, 32);
`endif
        chk("bypass ExRtData", ExRtData, 9);
        drive(ORI, 1, 0, 32'hDEADBEEF, 0, 0, 7, 1);
        tick();
        chk("wbawr0 ExRsData", ExRsData, 0);

        drive(ILL, 1, 0, 0, 0, 0, 0, 0);
        tick();
        chk("ill ExIllegal", 32'(ExIllegal), 1);
        chk("ill ExValid", 32'(ExValid), 1);
        chk("ill ExRegWrite", 32'(ExRegWrite), 0);

        drive(ADDI0, 1, 0, 4, 4, 0, 0, 0);
        tick();
        chk("rd0 ExRegWrite", 32'(ExRegWrite), 0);
        chk("rd0 ExValid", 32'(ExValid), 1);

        drive(LW, 1, 0, 0, 0, 0, 0, 0);
        tick();
        drive(ADDI3, 1, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rt-unused StallIF", 32'(StallIF), 0);
        tick();
        drive(LW, 1, 0, 0, 0, 0, 0, 0);
        tick();
        drive(BEQ, 1, 0, 0, 0, 0, 0, 0);
        #1;
        chk("beq StallIF", 32'(StallIF), 1);
        tick();
        tick();
        chk("beq ExBranch", 32'(ExBranch), 1);
        chk("beq StallCount", 32'(StallCount), 3);

        drive(ADDI, 0, 0, 1, 1, 0, 0, 0);
        tick();
        chk("invalid ExValid", 32'(ExValid), 0);

        for (int k = 0; k < 14; k++) begin
            drive(LW, 1, 0, 0, 0, 0, 0, 0);
            tick();
            drive(ADD, 1, 0, 0, 0, 0, 0, 0);
            tick();
            tick();
        end
        chk("sat StallCount", 32'(StallCount), 15);

        drive(ADDI, 1, 0, 32, 0, 0, 0, 0);
        tick();
        chk("pre-rst ExValid", 32'(ExValid), 1);
        #2;
        Rst_n = 1'b0;
        #1;
        chk("midrst ExValid", 32'(ExValid), 0);
        chk("midrst ExRsData", ExRsData, 0);
        chk("midrst ExImm", ExImm, 0);
        chk("midrst ExRd", 32'(ExRd), 0);
        chk("midrst ExRegWrite", 32'(ExRegWrite), 0);
        chk("midrst StallCount", 32'(StallCount), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction-decode stage sitting directly upstream of reg_file.
- Drives reg_file read addresses from the fetched instruction, decodes control, and captures Dout1/Dout2 plus control into the ID/EX pipeline register for the execute stage.
- Detects load-use hazards and stalls fetch/inserts bubbles.
- Keeps a saturating stall counter for performance debug.

Parameters:
- DATA_W, 32, datapath width; must match reg_file Din/Dout width.
- ADDR_W, 5, register address width; must match reg_file Ard/Awr width.
- STALL_CNT_W, 16, width of the saturating stall counter.

Ports:
- Clk  in  1  rising-edge clock, same clock as reg_file.
- Rst_n  in  1  asynchronous reset, active-low.
- Instr  in  32  instruction from IF/ID register.
- InstrValid  in  1  Instr is a real instruction; 0 means bubble.
- Flush  in  1  squash: ID/EX loads a bubble next edge.
- Ard1  out  ADDR_W  to reg_file; equals Instr[25:21] (rs), combinational.
- Ard2  out  ADDR_W  to reg_file; equals Instr[20:16] (rt), combinational.
- Dout1  in  DATA_W  rs data from reg_file.
- Dout2  in  DATA_W  rt data from reg_file.
- WbAwr  in  ADDR_W  writeback address, same net as reg_file Awr.
- WbDin  in  DATA_W  writeback data, same net as reg_file Din.
- WbWrEn  in  1  writeback enable, same net as reg_file WrEn.
- StallIF  out  1  combinational; IF/ID must hold its contents this cycle.
- ExValid  out  1  ID/EX register holds a valid instruction.
- ExRsData  out  DATA_W  captured rs operand.
- ExRtData  out  DATA_W  captured rt operand.
- ExImm  out  DATA_W  extended immediate.
- ExRd  out  ADDR_W  destination register.
- ExOpcode  out  6  Instr[31:26].
- ExFunct  out  6  Instr[5:0].
- ExRegWrite  out  1  instruction writes a register.
- ExMemRead  out  1  lw.
- ExMemWrite  out  1  sw.
- ExBranch  out  1  beq.
- ExIllegal  out  1  unknown opcode.
- StallCount  out  STALL_CNT_W  number of stall cycles, saturating.

Behaviour:
- Reset (Rst_n=0, async): all Ex* outputs are 0, ExValid=0, StallCount=0. StallIF is combinational and reads 0 because ExValid=0.
- Decode, opcode to flags:
  - 0x00 R-type: Rd=Instr[15:11], RegWrite=1, uses rt.
  - 0x08 addi: Rd=rt, RegWrite=1, sign-extended immediate.
  - 0x0C andi and 0x0D ori: Rd=rt, RegWrite=1, zero-extended immediate.
  - 0x23 lw: Rd=rt, RegWrite=1, MemRead=1, sign-extended.
  - 0x2B sw: RegWrite=0, MemWrite=1, uses rt, sign-extended.
  - 0x04 beq: RegWrite=0, Branch=1, uses rt, sign-extended.
  - Any other opcode: Illegal=1 and all control flags 0. It still propagates with ExValid=1 so EX can trap.
- Destination 0: if the decoded Rd is 0, RegWrite is forced to 0.
- Operands: if the address is 0, the operand is forced to 0; otherwise it is Dout1/Dout2 (with bypass, see Optional Feature).
- Load-use hazard:
  - Condition: InstrValid & ExValid & ExMemRead & ExRd!=0 & (ExRd==rs | (uses_rt & ExRd==rt)).
  - Response: StallIF=1 and ID/EX loads a bubble.
  - The bubble clears ExMemRead, so the stall lasts exactly 1 cycle; on the next edge the held instruction captures normally.
- Per-edge priority for the ID/EX register:
  1. Flush: bubble (ExValid=0, all control flags 0, data don't-care but held at 0).
  2. Hazard: bubble.
  3. InstrValid=1: capture with ExValid=1.
  4. InstrValid=0: bubble.
- Flush and hazard in the same cycle: Flush wins. StallIF still asserts, because it depends only on the hazard condition.
- Latency: exactly 1 cycle from Instr/Dout present to Ex* visible.
- StallCount increments on every edge where StallIF=1. It saturates at all-ones and does not wrap.
- Mid-operation reset clears the pipeline register and the counter immediately, without waiting for a clock edge.

Optional Feature:
- Macro: ID_WB_BYPASS_EN.
- Defined: if WbWrEn & WbAwr!=0 & WbAwr==rs, ExRsData captures WbDin instead of Dout1; same rule for rt/ExRtData. This covers the same-cycle reg_file write followed by read.
- Not defined: operands come only from Dout1/Dout2 (after the zero-register rule). A same-cycle write is not visible; the hazard unit is unchanged.

Test Plan:
- Reset: Rst_n=0 mid-stream with ExValid=1 -> all Ex* and StallCount are 0 immediately, before any clock edge.
- Capture, addi $3,$10,-4 (0x2143FFFC), Dout1=32 -> Ard1=10, Ard2=3; next edge ExValid=1, ExRsData=32, ExImm=0xFFFFFFFC, ExRd=3, ExRegWrite=1.
- Zero extend, ori $5,$0,0x8001 -> ExImm=0x00008001, ExRsData=0 even when Dout1=0xDEADBEEF is driven.
- Load-use: lw $3,0($10) followed by add $4,$3,$2 -> StallIF=1 for one cycle; one bubble cycle with ExValid=0; then add is captured; StallCount=1.
- Flush plus hazard together, and Flush alone with InstrValid=1 -> next ExValid=0 and ExRegWrite=0.
- Bypass (macro defined): WbWrEn=1, WbAwr=3, WbDin=2, rs=3, Dout1=32 -> ExRsData=2. With the macro undefined -> 32. WbAwr=0 -> never bypassed.
